// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Two-requester read arbiter in front of a single-port instruction memory
//   with combinational read data. The fetch port (f_*) and the debug/loader
//   port (d_*) share the memory. Grants are combinational. Read data is
//   registered into the granted port's rdata on the closing clock edge, and
//   that port's rvalid pulses for the following cycle (one-cycle latency).
//
//   Build option:
//     IMEM_ARB_RR_EN  defined   : simultaneous requests alternate (round-robin),
//                                 favouring the port not granted most recently.
//                     undefined : simultaneous requests always go to fetch.
//
//   Ports:
//     clk, rst_n            clock (rising edge), asynchronous active-low reset
//     f_req, f_addr         fetch read request and byte address
//     f_gnt                 fetch request accepted this cycle (combinational)
//     f_rvalid, f_rdata     fetch read response (registered)
//     d_req ... d_rdata     debug/loader port, same roles as the fetch port
//     mem_ce, mem_addr      memory enable and byte address (combinational)
//     mem_inst              memory combinational read data
module imem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_ce,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_inst
);

  typedef enum logic {
    LAST_F = 1'b0,
    LAST_D = 1'b1
  } last_e;

  last_e       r_last;
  logic        r_f_rvalid;
  logic        r_d_rvalid;
  logic [31:0] r_f_rdata;
  logic [31:0] r_d_rdata;

  logic        w_fetch_wins;
  logic        w_f_gnt;
  logic        w_d_gnt;

  // Conflict resolution. In the fixed-priority build the last-grant record
  // is still kept and referenced, but the OR with 1 makes fetch always win.
`ifdef IMEM_ARB_RR_EN
  assign w_fetch_wins = (r_last == LAST_D);
`else
  assign w_fetch_wins = (r_last == LAST_D) || 1'b1;
`endif

  always_comb begin
    w_f_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (f_req && d_req) begin
      w_f_gnt = w_fetch_wins;
      w_d_gnt = !w_fetch_wins;
    end else begin
      w_f_gnt = f_req;
      w_d_gnt = d_req;
    end
  end

  // Memory address mux; zero when idle. Low bits pass through untouched.
  always_comb begin
    mem_ce   = 1'b0;
    mem_addr = '0;
    if (w_f_gnt) begin
      mem_ce   = 1'b1;
      mem_addr = f_addr;
    end else if (w_d_gnt) begin
      mem_ce   = 1'b1;
      mem_addr = d_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= LAST_D;
      r_f_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_f_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_f_rvalid <= w_f_gnt;
      r_d_rvalid <= w_d_gnt;
      if (w_f_gnt) begin
        r_f_rdata <= mem_inst;
      end
      if (w_d_gnt) begin
        r_d_rdata <= mem_inst;
      end
      if (w_f_gnt) begin
        r_last <= LAST_F;
      end else if (w_d_gnt) begin
        r_last <= LAST_D;
      end
    end
  end

  assign f_gnt    = w_f_gnt;
  assign d_gnt    = w_d_gnt;
  assign f_rvalid = r_f_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign f_rdata  = r_f_rdata;
  assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_ce;
  logic [31:0] mem_addr;
  logic [31:0] mem_inst;

  int n_pass;
  int n_total;

  imem_arbiter #(.ADDR_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_ce   (mem_ce),
    .mem_addr (mem_addr),
    .mem_inst (mem_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as seen by the arbiter.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0000_0013;
      32'h0000_0004: mem_word = 32'h0050_0093;
      32'h0000_0008: mem_word = 32'h00A0_0113;
      32'h0000_0010: mem_word = 32'h1234_5678;
      32'h0000_0100: mem_word = 32'hDEAD_BEEF;
      default:       mem_word = a ^ 32'hC0DE_0000;
    endcase
  endfunction

  always_comb mem_inst = mem_word(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        fr;
    logic [31:0] fa;
    logic        dr;
    logic [31:0] da;
    logic        e_fg;
    logic        e_dg;
    logic        e_ce;
    logic [31:0] e_ma;
    logic        e_frv;
    logic [31:0] e_frd;
    logic        e_drv;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    f_req   = 1'b1;
    f_addr  = 32'h8;
    d_req   = 1'b0;
    d_addr  = 32'h0;

    // Combinational path live during reset, registered outputs held clear.
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("rst_f_gnt",    {31'b0, f_gnt},    32'h1);
      chk("rst_d_gnt",    {31'b0, d_gnt},    32'h0);
      chk("rst_mem_ce",   {31'b0, mem_ce},   32'h1);
      chk("rst_mem_addr", mem_addr,          32'h8);
      chk("rst_f_rvalid", {31'b0, f_rvalid}, 32'h0);
      chk("rst_f_rdata",  f_rdata,           32'h0);
      chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'h0);
      chk("rst_d_rdata",  d_rdata,           32'h0);
      @(posedge clk); #1;
    end
    f_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_f_rvalid", {31'b0, f_rvalid}, 32'h0);

    //             fr    fa          dr    da          fg    dg    ce    ma          frv   frd             drv   drd
    vecs[0] = '{1'b1, 32'h4,   1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h4,   1'b1, 32'h0050_0093, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0050_0093, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0050_0093, 1'b0, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 32'h0,   1'b1, 32'h7,   1'b0, 1'b1, 1'b1, 32'h7,   1'b0, 32'h0050_0093, 1'b1, 32'hC0DE_0007};
    vecs[4] = '{1'b1, 32'h20,  1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h20,  1'b1, 32'hC0DE_0020, 1'b0, 32'hC0DE_0007};
    vecs[5] = '{1'b1, 32'h20,  1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h20,  1'b1, 32'hC0DE_0020, 1'b0, 32'hC0DE_0007};

    for (int i = 0; i < 6; i++) begin
      f_req  = vecs[i].fr;
      f_addr = vecs[i].fa;
      d_req  = vecs[i].dr;
      d_addr = vecs[i].da;
      #2;
      chk("vec_f_gnt",    {31'b0, f_gnt},  {31'b0, vecs[i].e_fg});
      chk("vec_d_gnt",    {31'b0, d_gnt},  {31'b0, vecs[i].e_dg});
      chk("vec_mem_ce",   {31'b0, mem_ce}, {31'b0, vecs[i].e_ce});
      chk("vec_mem_addr", mem_addr,        vecs[i].e_ma);
      @(posedge clk); #1;
      chk("vec_f_rvalid", {31'b0, f_rvalid}, {31'b0, vecs[i].e_frv});
      chk("vec_f_rdata",  f_rdata,           vecs[i].e_frd);
      chk("vec_d_rvalid", {31'b0, d_rvalid}, {31'b0, vecs[i].e_drv});
      chk("vec_d_rdata",  d_rdata,           vecs[i].e_drd);
    end
    f_req = 1'b0;
    d_req = 1'b0;

    // Conflict: reset first so last-grant points at debug.
    rst_n = 1'b0;
    #2;
    chk("rst2_d_rdata", d_rdata, 32'h0);
    chk("rst2_f_rdata", f_rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    f_req  = 1'b1;
    f_addr = 32'h0;
    d_req  = 1'b1;
    d_addr = 32'h100;
    for (int c = 0; c < 4; c++) begin
      logic        e_fg;
      logic [31:0] e_frd;
      logic [31:0] e_drd;
`ifdef IMEM_ARB_RR_EN
      e_fg  = (c % 2 == 0);
      e_frd = 32'h0000_0013;
      e_drd = (c >= 1) ? 32'hDEAD_BEEF : 32'h0;
`else
      e_fg  = 1'b1;
      e_frd = 32'h0000_0013;
      e_drd = 32'h0;
`endif
      #2;
      chk("cf_f_gnt",    {31'b0, f_gnt}, {31'b0, e_fg});
      chk("cf_d_gnt",    {31'b0, d_gnt}, {31'b0, !e_fg});
      chk("cf_mem_addr", mem_addr,       e_fg ? 32'h0 : 32'h100);
      @(posedge clk); #1;
      chk("cf_f_rvalid", {31'b0, f_rvalid}, {31'b0, e_fg});
      chk("cf_d_rvalid", {31'b0, d_rvalid}, {31'b0, !e_fg});
      chk("cf_f_rdata",  f_rdata,           e_frd);
      chk("cf_d_rdata",  d_rdata,           e_drd);
    end
    f_req = 1'b0;
    #2;
    chk("drop_d_gnt",    {31'b0, d_gnt}, 32'h1);
    chk("drop_f_gnt",    {31'b0, f_gnt}, 32'h0);
    chk("drop_mem_addr", mem_addr,       32'h100);
    @(posedge clk); #1;
    chk("drop_d_rvalid", {31'b0, d_rvalid}, 32'h1);
    chk("drop_d_rdata",  d_rdata,           32'hDEAD_BEEF);
    chk("drop_f_rvalid", {31'b0, f_rvalid}, 32'h0);
    chk("drop_f_rdata",  f_rdata,           32'h0000_0013);

    // Reset lands on a granted debug read before its closing edge.
    d_addr = 32'h10;
    #2;
    chk("mid_d_gnt",    {31'b0, d_gnt}, 32'h1);
    chk("mid_mem_addr", mem_addr,       32'h10);
    #1;
    rst_n = 1'b0;
    d_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rel_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    chk("mid_rel_d_rdata",  d_rdata,           32'h0);
    @(posedge clk); #1;
    chk("mid_after_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    chk("mid_after_d_rdata",  d_rdata,           32'h0);
    chk("mid_after_f_rvalid", {31'b0, f_rvalid}, 32'h0);

    // Idle after a fetch: rdata holds, nothing drives memory.
    f_req  = 1'b1;
    f_addr = 32'h4;
    @(posedge clk); #1;
    f_req = 1'b0;
    chk("pre_idle_f_rdata", f_rdata, 32'h0050_0093);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("idle_mem_ce",   {31'b0, mem_ce}, 32'h0);
      chk("idle_mem_addr", mem_addr,        32'h0);
      @(posedge clk); #1;
      chk("idle_f_rvalid", {31'b0, f_rvalid}, 32'h0);
      chk("idle_d_rvalid", {31'b0, d_rvalid}, 32'h0);
      chk("idle_f_rdata",  f_rdata,           32'h0050_0093);
      chk("idle_d_rdata",  d_rdata,           32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
